rr_arbiter_4: RTL
=================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource, such as a bus or shared datapath port.
- Outputs the winner as a one-hot grant, a 2-bit binary index and a valid flag, so consumers get encoded-index form directly.
- Each grant is held until the owner drops its request or a hold limit expires.
- Priority then rotates past the last owner.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may keep the grant (legal range 1..255).
- CNT_W, derived $clog2(MAX_HOLD) with a minimum of 1, width of the hold counter (not user-set).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; low blocks new grants.
- req  input  4  request vector; req[i] high = requester i wants the resource.
- gnt  output  4  one-hot grant; all zero when idle.
- gnt_idx  output  2  binary index of the granted requester; req[0]=0 … req[3]=3; forced 0 when gnt_valid=0.
- gnt_valid  output  1  high while any grant is active; equals |gnt.

Behaviour:
- Reset, with rst high at a clock edge:
  - state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0.
  - Priority pointer ptr=0, hold_cnt=0.
  - Reset overrides everything, including an active grant mid-hold; the grant drops at that edge.
- All outputs are registered. There is no combinational path from req to gnt.
- Winner selection (pick):
  - Scan req starting at index ptr, then ptr+1, … wrapping mod 4.
  - The first asserted bit wins.
- IDLE state:
  - If en=1 and |req=1: at the next edge, gnt/gnt_idx/gnt_valid load pick(req,ptr), hold_cnt=0, go to BUSY.
  - Request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE with outputs zero.
- BUSY state, owner o=gnt_idx:
  - Release condition R = (req[o]==0) OR (hold_cnt==MAX_HOLD-1).
  - If not R: hold_cnt increments and the grant is unchanged.
  - If R: ptr<=o+1 (mod 4), hold_cnt<=0, then:
    - If en=1 and a request remains, re-grant at the same edge to pick(req',o+1). req' is req with bit o masked only when req[o]==0. This gives back-to-back grants with no bubble cycle.
    - A hold-expired owner still requesting is eligible, but at lowest priority. If it is the only requester, it is re-granted immediately with a fresh hold count.
    - Otherwise: go to IDLE, outputs zero.
- en=0 during BUSY: the current grant runs to its normal release, then goes to IDLE. No re-grant while en=0.
- Hold counter: counts cycles granted minus 1 and saturates by construction at MAX_HOLD-1.
  - MAX_HOLD=1 means every grant lasts exactly one cycle, and requesters rotate each cycle.
- Simultaneous events:
  - Requests arriving in the same cycle as a release are considered in that re-arbitration.
  - A requester's req rising while another holds the grant waits; no preemption except hold expiry.
- gnt is always one-hot or zero. gnt_idx is always consistent with gnt.

Test Plan:
- Reset/idle: hold rst=1 for 2 cycles with req=1111, then rst=0 and req=0000 → gnt=0000, gnt_idx=0, gnt_valid=0 every cycle.
- Single requester:
  - req=0100 from cycle 0 with en=1 → cycle 1: gnt=0100, gnt_idx=2, valid=1.
  - Drop req at cycle 5 → cycle 6: gnt=0000, valid=0.
- Round robin: req=1111 held constant with MAX_HOLD=2 → grants 0,0,1,1,2,2,3,3,0… with no idle cycle between owners.
- Hold expiry with lone requester: MAX_HOLD=3, req=0010 constant → gnt=0010 continuous. hold_cnt walks 0,1,2,0,1,2 and valid never drops.
- Early release and wrap:
  - Owner 3 drops req while req[0]=1 and req[1]=1 → next edge gnt=0001 (ptr wrapped to 0), gnt_idx=0.
- Enable and mid-grant reset:
  - en=0 while req=0011 idle → no grant.
  - en=1 → grant 0 after 1 cycle.
  - Assert rst during the grant → next edge all outputs zero; after rst=0, owner is requester 0 again (ptr=0).

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a bounded hold time.
//
// A granted requester keeps the resource until it drops its request or until it
// has held it for MAX_HOLD consecutive cycles. Priority then rotates to the
// requester after the last owner. All outputs are registered, so there is no
// combinational path from req to gnt. A release and a new grant can happen on
// the same edge, which gives back-to-back grants with no idle cycle.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset
//   en         in   1  arbitration enable; low blocks new grants
//   req        in   4  request vector, bit i = requester i
//   gnt        out  4  one-hot grant, zero when idle
//   gnt_idx    out  2  binary index of the owner, zero when idle
//   gnt_valid  out  1  high while a grant is active (equals |gnt)

module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_idx;
  logic             r_gnt_valid;

  state_e           w_state_d;
  logic [1:0]       w_ptr_d;
  logic [CNT_W-1:0] w_hold_cnt_d;
  logic [3:0]       w_gnt_d;
  logic [1:0]       w_gnt_idx_d;
  logic             w_gnt_valid_d;

  logic [1:0]       w_start;
  logic [2:0]       w_pick;      // {found, index}
  logic             w_hold_last;
  logic             w_release;

  // Scan r starting at 'start' and wrapping mod 4; the first set bit wins.
  // Iterating from the farthest offset down lets the nearest hit overwrite.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While busy, re-arbitration starts just past the owner, so an owner whose
  // hold expired but still requests is considered last. When the owner has
  // dropped its request its bit is already zero, so no explicit mask is needed.
  assign w_start     = (r_state == StBusy) ? (r_gnt_idx + 2'd1) : r_ptr;
  assign w_pick      = pick(req, w_start);
  assign w_hold_last = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_release   = !req[r_gnt_idx] || w_hold_last;

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_hold_cnt_d  = r_hold_cnt;
    w_gnt_d       = r_gnt;
    w_gnt_idx_d   = r_gnt_idx;
    w_gnt_valid_d = r_gnt_valid;

    unique case (r_state)
      StIdle: begin
        if (en && w_pick[2]) begin
          w_state_d     = StBusy;
          w_gnt_d       = 4'b0001 << w_pick[1:0];
          w_gnt_idx_d   = w_pick[1:0];
          w_gnt_valid_d = 1'b1;
          w_hold_cnt_d  = '0;
        end
      end
      StBusy: begin
        if (!w_release) begin
          w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
        end else begin
          w_ptr_d      = r_gnt_idx + 2'd1;
          w_hold_cnt_d = '0;
          if (en && w_pick[2]) begin
            w_gnt_d       = 4'b0001 << w_pick[1:0];
            w_gnt_idx_d   = w_pick[1:0];
            w_gnt_valid_d = 1'b1;
          end else begin
            w_state_d     = StIdle;
            w_gnt_d       = '0;
            w_gnt_idx_d   = '0;
            w_gnt_valid_d = 1'b0;
          end
        end
      end
      default: begin
        w_state_d     = StIdle;
        w_gnt_d       = '0;
        w_gnt_idx_d   = '0;
        w_gnt_valid_d = 1'b0;
        w_hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_hold_cnt  <= w_hold_cnt_d;
      r_gnt       <= w_gnt_d;
      r_gnt_idx   <= w_gnt_idx_d;
      r_gnt_valid <= w_gnt_valid_d;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule
